axil_master_arbiter: RTL and testbench

//  Shares the single AXI-Lite master between NREQ on-chip requesters (e.g. core LSU, UART poller).

---
 rtl/axil_master_arbiter_pkg.sv | 18 +
 rtl/axil_master_arbiter_if.sv | 41 ++++
 rtl/axil_master_arbiter_rr_arbiter.sv | 35 +++
 rtl/axil_master_arbiter.sv | 163 ++++++++++++++++
 tb/tb_axil_master_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_master_arbiter_pkg.sv
// Shared types and helpers for the AXI-Lite master arbiter slice.
package axil_arb_pkg;

  localparam int AXIL_AW = 32;
  localparam int AXIL_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axil_master_arbiter_if.sv
// Requester-side and AXI-Lite-master-side signal bundle for axil_master_arbiter.
interface axil_master_arbiter_if import axil_arb_pkg::*; #(
  parameter int NREQ = 2,
  parameter int AW   = AXIL_AW,
  parameter int DW   = AXIL_DW
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*AW-1:0]     req_addr;
  logic [NREQ*DW-1:0]     req_wdata;
  logic [NREQ*DW/8-1:0]   req_wstrb;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DW-1:0]          rsp_rdata;
  logic                   rsp_err;
  logic                   busy;
  logic                   m_start_read;
  logic                   m_start_write;
  logic [AW-1:0]          m_addr;
  logic [DW-1:0]          m_wdata;
  logic [DW/8-1:0]        m_wstrb;
  logic                   m_rvalid;
  logic                   m_rready;
  logic                   m_bvalid;
  logic                   m_bready;
  logic [DW-1:0]          m_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  m_rvalid, m_rready, m_bvalid, m_bready, m_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output m_start_read, m_start_write, m_addr, m_wdata, m_wstrb
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output m_rvalid, m_rready, m_bvalid, m_bready, m_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  m_start_read, m_start_write, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/axil_master_arbiter_rr_arbiter.sv
// Round-robin picker: lowest requester at or above ptr wins, else lowest overall.
module rr_arbiter import axil_arb_pkg::*; #(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);
  logic [NREQ-1:0] mask_s;
  logic [NREQ-1:0] masked_s;
  logic [NREQ-1:0] pick_s;
  logic [IW-1:0]   idx_s;

  // masked priority pick with wrap-around fallback to the unmasked vector
  always_comb begin
    mask_s = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      mask_s[i] = (i >= int'(ptr));
    end
    masked_s = req & mask_s;
    pick_s   = (|masked_s) ? masked_s : req;
    grant    = pick_s & (~pick_s + NREQ'(1'b1));
    idx_s    = {IW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      idx_s = idx_s | (grant[i] ? IW'(i) : {IW{1'b0}});
    end
  end

  assign idx = idx_s;
  assign any = |req;

endmodule

// File: rtl/axil_master_arbiter.sv
// Round-robin share of one AXI-Lite master among NREQ requesters.
// Optional WAIT watchdog enabled by defining AXIL_ARB_TIMEOUT_EN.
module axil_master_arbiter import axil_arb_pkg::*; #(
  parameter int NREQ           = 2,
  parameter int AW             = AXIL_AW,
  parameter int DW             = AXIL_DW,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  axil_master_arbiter_if.master bus
);
  localparam int IW = idx_w(NREQ);
  localparam int SW = DW / 8;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_param_check
    $error("axil_master_arbiter: parameter out of range");
  end

  arb_state_t      state_r;
  logic [IW-1:0]   rr_ptr_r;
  logic [IW-1:0]   gnt_idx_r;
  logic            write_r;
  logic [AW-1:0]   addr_r;
  logic [DW-1:0]   wdata_r;
  logic [SW-1:0]   wstrb_r;
  logic            start_rd_r;
  logic            start_wr_r;
  logic            busy_r;
  logic [NREQ-1:0] rsp_valid_r;
  logic [DW-1:0]   rsp_rdata_r;

  logic [NREQ-1:0] pick_grant_s;
  logic [IW-1:0]   pick_idx_s;
  logic            pick_any_s;
  logic            accept_s;
  logic            done_s;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  assign accept_s = areset_n && (state_r == ST_IDLE) && pick_any_s;
  // only the handshake matching the latched direction ends the transaction
  assign done_s   = write_r ? (bus.m_bvalid && bus.m_bready)
                            : (bus.m_rvalid && bus.m_rready);

`ifdef AXIL_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_r;
  logic        tmo_hit_s;
  logic        rsp_err_r;
  assign tmo_hit_s = (tmo_cnt_r == 16'(TIMEOUT_CYCLES - 1));
`endif

  // transaction FSM: accept, issue pulse, wait for completion, respond
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= {IW{1'b0}};
      gnt_idx_r   <= {IW{1'b0}};
      write_r     <= 1'b0;
      addr_r      <= {AW{1'b0}};
      wdata_r     <= {DW{1'b0}};
      wstrb_r     <= {SW{1'b0}};
      start_rd_r  <= 1'b0;
      start_wr_r  <= 1'b0;
      busy_r      <= 1'b0;
      rsp_valid_r <= {NREQ{1'b0}};
      rsp_rdata_r <= {DW{1'b0}};
`ifdef AXIL_ARB_TIMEOUT_EN
      tmo_cnt_r   <= 16'd0;
      rsp_err_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            gnt_idx_r  <= pick_idx_s;
            write_r    <= bus.req_write[pick_idx_s];
            addr_r     <= bus.req_addr[int'(pick_idx_s)*AW +: AW];
            wdata_r    <= bus.req_wdata[int'(pick_idx_s)*DW +: DW];
            wstrb_r    <= bus.req_wstrb[int'(pick_idx_s)*SW +: SW];
            start_rd_r <= ~bus.req_write[pick_idx_s];
            start_wr_r <= bus.req_write[pick_idx_s];
            busy_r     <= 1'b1;
            state_r    <= ST_ISSUE;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          start_rd_r <= 1'b0;
          start_wr_r <= 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
          tmo_cnt_r  <= 16'd0;
`endif
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_s) begin
            rsp_valid_r <= NREQ'(1'b1) << gnt_idx_r;
            rsp_rdata_r <= write_r ? {DW{1'b0}} : bus.m_rdata;
`ifdef AXIL_ARB_TIMEOUT_EN
            rsp_err_r   <= 1'b0;
`endif
            state_r     <= ST_RESP;
`ifdef AXIL_ARB_TIMEOUT_EN
          end else if (tmo_hit_s) begin
            rsp_valid_r <= NREQ'(1'b1) << gnt_idx_r;
            rsp_rdata_r <= {DW{1'b0}};
            rsp_err_r   <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            tmo_cnt_r   <= tmo_cnt_r + 16'd1;
            state_r     <= ST_WAIT;
          end
`else
          end else begin
            state_r     <= ST_WAIT;
          end
`endif
        end
        ST_RESP: begin
          rsp_valid_r <= {NREQ{1'b0}};
          rsp_rdata_r <= {DW{1'b0}};
`ifdef AXIL_ARB_TIMEOUT_EN
          rsp_err_r   <= 1'b0;
`endif
          rr_ptr_r    <= (gnt_idx_r == IW'(NREQ - 1)) ? {IW{1'b0}} : gnt_idx_r + IW'(1'b1);
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          start_rd_r  <= 1'b0;
          start_wr_r  <= 1'b0;
          busy_r      <= 1'b0;
          rsp_valid_r <= {NREQ{1'b0}};
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = accept_s ? pick_grant_s : {NREQ{1'b0}};
  assign bus.rsp_valid     = rsp_valid_r;
  assign bus.rsp_rdata     = rsp_rdata_r;
  assign bus.busy          = busy_r;
  assign bus.m_start_read  = start_rd_r;
  assign bus.m_start_write = start_wr_r;
  assign bus.m_addr        = addr_r;
  assign bus.m_wdata       = wdata_r;
  assign bus.m_wstrb       = wstrb_r;
`ifdef AXIL_ARB_TIMEOUT_EN
  assign bus.rsp_err       = rsp_err_r;
`else
  assign bus.rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Bench for axil_master_arbiter: directed scenarios plus randomized traffic against a timeline model.
`timescale 1ns/1ps
module tb_axil_master_arbiter;
  import axil_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = AXIL_AW;
  localparam int DW   = AXIL_DW;
  localparam int SW   = DW / 8;
  localparam int TMO  = 8;

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;

  axil_master_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  axil_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  int              t_now = 0;
  bit              have_txn = 1'b0;
  int              t_acc = 0;
  int              t_done = -1;
  int              w = 0;
  bit              wr = 1'b0;
  int              ptr = 0;
  logic [AW-1:0]   e_addr = '0;
  logic [DW-1:0]   e_wdata = '0;
  logic [SW-1:0]   e_wstrb = '0;
  logic [DW-1:0]   e_rdata = '0;
  bit              e_err = 1'b0;
  logic [NREQ-1:0] e_ready = '0;

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  always @(negedge aclk) begin : cmp
    bit idle;
    int g;
    logic [NREQ-1:0] e_rsp;
    #3;
    t_now++;
    if (!areset_n) begin
      have_txn = 1'b0; ptr = 0; e_ready = '0;
      e_addr = '0; e_wdata = '0; e_wstrb = '0;
    end else begin
      idle = !have_txn || (t_done >= 0 && t_now > t_done + 1);
      if (idle) have_txn = 1'b0;
      g = idle ? pick(bus.req_valid, ptr) : -1;
      e_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
      e_rsp = (have_txn && t_done >= 0 && t_now == t_done + 1) ? (NREQ'(1) << w) : '0;
      chk("req_ready", bus.req_ready, e_ready);
      chk("busy", bus.busy, !idle);
      chk("start_read", bus.m_start_read, have_txn && t_now == t_acc + 1 && !wr);
      chk("start_write", bus.m_start_write, have_txn && t_now == t_acc + 1 && wr);
      chk("rsp_valid", bus.rsp_valid, e_rsp);
      chk("m_addr", bus.m_addr, e_addr);
      chk("m_wdata", bus.m_wdata, e_wdata);
      chk("m_wstrb", bus.m_wstrb, e_wstrb);
      if (e_rsp != '0) begin
        chk("rsp_rdata", bus.rsp_rdata, e_rdata);
        chk("rsp_err", bus.rsp_err, e_err);
      end
      if (g >= 0) begin
        have_txn = 1'b1; t_acc = t_now; t_done = -1; w = g;
        wr = bus.req_write[g];
        e_addr  = bus.req_addr[g*AW +: AW];
        e_wdata = bus.req_wdata[g*DW +: DW];
        e_wstrb = bus.req_wstrb[g*SW +: SW];
        ptr = (g + 1) % NREQ;
      end else if (have_txn && t_done < 0 && t_now >= t_acc + 2) begin
        if (wr ? (bus.m_bvalid && bus.m_bready) : (bus.m_rvalid && bus.m_rready)) begin
          t_done = t_now; e_rdata = wr ? '0 : bus.m_rdata; e_err = 1'b0;
        end
`ifdef AXIL_ARB_TIMEOUT_EN
        else if (t_now == t_acc + 1 + TMO) begin
          t_done = t_now; e_rdata = '0; e_err = 1'b1;
        end
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(negedge aclk); endtask

  task automatic hs_clear();
    bus.m_rvalid = 1'b0; bus.m_rready = 1'b0; bus.m_bvalid = 1'b0; bus.m_bready = 1'b0;
  endtask

  task automatic set_req(input int i, input bit wrt, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    bus.req_valid[i] = 1'b1; bus.req_write[i] = wrt;
    bus.req_addr[i*AW +: AW] = a; bus.req_wdata[i*DW +: DW] = d; bus.req_wstrb[i*SW +: SW] = s;
  endtask

  task automatic do_reset();
    tick(); areset_n = 1'b0;
    tick(); areset_n = 1'b1;
  endtask

  task automatic do_txn(input int i, input bit wrt, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input int dly, input bit stray, input logic [DW-1:0] rd);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << i;
    tick(); set_req(i, wrt, a, d, s); #4;
    chk("accept_ready", bus.req_ready, oh);
    tick(); bus.req_valid[i] = 1'b0; #4;
    chk("issue_start_read", bus.m_start_read, !wrt);
    chk("issue_start_write", bus.m_start_write, wrt);
    chk("issue_addr", bus.m_addr, a);
    for (int k = 0; k < dly; k++) begin
      tick();
      if (stray) begin
        if (wrt) begin bus.m_rvalid = 1'b1; bus.m_rready = 1'b1; end
        else begin bus.m_bvalid = 1'b1; bus.m_bready = 1'b1; end
      end
      #4;
      chk("wait_no_rsp", bus.rsp_valid, '0);
      chk("wait_addr_stable", bus.m_addr, a);
      chk("wait_wdata_stable", bus.m_wdata, d);
      chk("wait_wstrb_stable", bus.m_wstrb, s);
    end
    tick(); hs_clear(); bus.m_rdata = rd;
    if (wrt) begin bus.m_bvalid = 1'b1; bus.m_bready = 1'b1; end
    else begin bus.m_rvalid = 1'b1; bus.m_rready = 1'b1; end
    tick(); hs_clear(); bus.m_rdata = $urandom; #4;
    chk("rsp_onehot", bus.rsp_valid, oh);
    chk("rsp_data", bus.rsp_rdata, wrt ? '0 : rd);
    chk("rsp_err_clear", bus.rsp_err, 1'b0);
    chk("resp_addr_stable", bus.m_addr, a);
  endtask

  initial begin
    logic [NREQ-1:0] seq [4];
    int n;
    seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_wstrb = '0;
    bus.m_rdata = '0; hs_clear();
    areset_n = 1'b0;
    repeat (3) tick();
    #4;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, '0);
    chk("rst_start", {bus.m_start_read, bus.m_start_write}, 2'b00);
    chk("rst_m_addr", bus.m_addr, '0);
    chk("rst_rsp_rdata", bus.rsp_rdata, '0);
    tick(); areset_n = 1'b1;

    // single read on requester 0
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF);

    // two contending requesters alternate
    do_reset();
    tick(); set_req(0, 1'b0, 32'h100, 32'h0, 4'h0); set_req(1, 1'b0, 32'h200, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      #4; chk("grant_order", bus.req_ready, seq[k]);
      tick(); #4; chk("grant_addr", bus.m_addr, (seq[k] == 2'b01) ? 32'h100 : 32'h200);
      tick(); bus.m_rvalid = 1'b1; bus.m_rready = 1'b1;
      tick(); hs_clear(); #4; chk("grant_rsp", bus.rsp_valid, seq[k]);
      tick();
    end
    bus.req_valid = '0;

    // write on requester 1 with a long wait, then stray B during a read
    do_txn(1, 1'b1, 32'h20, 32'hA5A5, 4'hF, 3, 1'b0, 32'h12345678);
    do_txn(0, 1'b0, 32'h44, 32'h0, 4'h0, 3, 1'b1, 32'hCAFE0001);

    // reset in WAIT, pointer returns to 0
    tick(); set_req(1, 1'b0, 32'h55, 32'h0, 4'h0); #4;
    chk("r5_accept", bus.req_ready, 2'b10);
    tick(); bus.req_valid = '0;
    tick();
    tick(); areset_n = 1'b0;
    tick(); areset_n = 1'b1;
    set_req(0, 1'b0, 32'h60, 32'h0, 4'h0); set_req(1, 1'b0, 32'h70, 32'h0, 4'h0); #4;
    chk("r5_busy", bus.busy, 1'b0);
    chk("r5_no_rsp", bus.rsp_valid, '0);
    chk("r5_m_addr", bus.m_addr, '0);
    chk("r5_ptr_zero", bus.req_ready, 2'b01);
    tick(); bus.req_valid = '0; #4; chk("r5_no_rsp2", bus.rsp_valid, '0);
    tick(); bus.m_rvalid = 1'b1; bus.m_rready = 1'b1; bus.m_rdata = 32'h0BADF00D;
    tick(); hs_clear(); #4;
    chk("r5_rsp", bus.rsp_valid, 2'b01);
    chk("r5_rdata", bus.rsp_rdata, 32'h0BADF00D);

    // no completion: watchdog response or indefinite wait
    tick(); set_req(0, 1'b0, 32'h80, 32'h0, 4'h0);
    tick(); bus.req_valid = '0;
    n = 0;
`ifdef AXIL_ARB_TIMEOUT_EN
    for (int k = 0; k < 40; k++) begin
      tick(); #4;
      if (bus.rsp_valid != '0) break;
      n++;
    end
    chk("tmo_wait_cycles", n, TMO);
    chk("tmo_rsp", bus.rsp_valid, 2'b01);
    chk("tmo_err", bus.rsp_err, 1'b1);
    chk("tmo_rdata", bus.rsp_rdata, '0);
`else
    for (int k = 0; k < 20; k++) begin
      tick(); #4;
      if (bus.rsp_valid != '0) break;
      n++;
    end
    chk("hold_wait_cycles", n, 20);
    chk("hold_busy", bus.busy, 1'b1);
    tick(); bus.m_rvalid = 1'b1; bus.m_rready = 1'b1; bus.m_rdata = 32'h77;
    tick(); hs_clear(); #4;
    chk("hold_rsp", bus.rsp_valid, 2'b01);
    chk("hold_err", bus.rsp_err, 1'b0);
`endif

    // randomized traffic, stray handshakes and occasional resets
    for (int c = 0; c < 2500; c++) begin
      tick();
      areset_n = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && e_ready[i]) bus.req_valid[i] = 1'b0;
        else if (bus.req_valid[i] && $urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
        else if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
      end
      bus.m_rvalid = ($urandom_range(0, 3) == 0);
      bus.m_rready = 1'($urandom_range(0, 1));
      bus.m_bvalid = ($urandom_range(0, 3) == 0);
      bus.m_bready = 1'($urandom_range(0, 1));
      bus.m_rdata  = $urandom;
    end
    tick(); areset_n = 1'b1; bus.req_valid = '0; hs_clear();
    repeat (20) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t act=running exp=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
